// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source encodings and FIFO entry type for the CDB arbiter.
// Imported by cdb_src_buf and cdb_arbiter.
package cdb_arbiter_pkg;

   localparam int DAT_W         = 32;
   localparam int ROB_BIT       = 4;
   localparam int REG_BIT       = 5;
   localparam int CDB_BUF_DEPTH = 2;

   localparam logic CDB_SRC_ALU = 1'b0;
   localparam logic CDB_SRC_LSB = 1'b1;

   typedef struct packed {
      logic [ROB_BIT-1:0] rob_id;
      logic [REG_BIT-1:0] rd;
      logic [DAT_W-1:0]   data;
   } cdb_entry_t;

   localparam int ENTRY_W = $bits(cdb_entry_t);

   function automatic logic other_src(input logic src);
      return ~src;
   endfunction

endpackage

// File: rtl/cdb_src_buf.sv
// Per-source result FIFO holding {rob_id, rd, data}; DEPTH must be a power of two.
// Pointers wrap naturally at PTR_W bits; flush empties the buffer at the next edge.
module cdb_src_buf
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = CDB_BUF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  cdb_entry_t                   push_entry,
   input  logic                         pop,
   output logic                         full,
   output logic                         empty,
   output cdb_entry_t                   head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   cdb_entry_t       mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   assign full   = (count_r == CNT_W'(DEPTH));
   assign empty  = (count_r == {CNT_W{1'b0}});
   assign push_s = push & ~full & ~flush;
   assign pop_s  = pop & ~empty & ~flush;
   assign head   = mem_r[rd_ptr_r];
   assign count  = count_r;

   // Entry storage; only slots between rd_ptr and wr_ptr are live
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= cdb_entry_t'({ENTRY_W{1'b0}});
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= push_entry;
      end
   end

   // Read/write pointers and occupancy count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB broadcast between the ALU and LSB FIFOs.
// Optional macro CDB_FLUSH_EN adds a flush port that empties both FIFOs and resets rr.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               alu_valid,
   input  logic [ROB_BIT-1:0] alu_rob_id,
   input  logic [REG_BIT-1:0] alu_rd,
   input  logic [DAT_W-1:0]   alu_data,
   output logic               alu_ready,
   input  logic               lsb_valid,
   input  logic [ROB_BIT-1:0] lsb_rob_id,
   input  logic [REG_BIT-1:0] lsb_rd,
   input  logic [DAT_W-1:0]   lsb_data,
   output logic               lsb_ready,
`ifdef CDB_FLUSH_EN
   input  logic               flush,
`endif
   output logic               cdb_en,
   output logic [ROB_BIT-1:0] cdb_rob_id,
   output logic [REG_BIT-1:0] cdb_rd,
   output logic [DAT_W-1:0]   cdb_data,
   output logic               cdb_src
);

   localparam int CNT_W = $clog2(BUF_DEPTH+1);

   logic             flush_s;
   logic             alu_push_s;
   logic             lsb_push_s;
   logic             alu_full_s;
   logic             lsb_full_s;
   logic             alu_empty_s;
   logic             lsb_empty_s;
   logic [CNT_W-1:0] alu_count_s;
   logic [CNT_W-1:0] lsb_count_s;
   cdb_entry_t       alu_head_s;
   cdb_entry_t       lsb_head_s;
   logic             grant_alu_s;
   logic             grant_lsb_s;
   logic             grant_src_s;

   logic             rr_r;
   logic             cdb_en_r;
   cdb_entry_t       cdb_entry_r;
   logic             cdb_src_r;

`ifdef CDB_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // A full FIFO never accepts, even if it pops in the same cycle
   assign alu_ready = en & rst & ~flush_s & ~alu_full_s & (alu_count_s < CNT_W'(BUF_DEPTH));
   assign lsb_ready = en & rst & ~flush_s & ~lsb_full_s & (lsb_count_s < CNT_W'(BUF_DEPTH));

   // Tag 0 means "no ROB entry": the handshake completes but nothing is stored
   assign alu_push_s = alu_valid & alu_ready & (alu_rob_id != {ROB_BIT{1'b0}});
   assign lsb_push_s = lsb_valid & lsb_ready & (lsb_rob_id != {ROB_BIT{1'b0}});

   cdb_src_buf #(.DEPTH(BUF_DEPTH)) u_alu_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_s),
      .push       (alu_push_s),
      .push_entry ({alu_rob_id, alu_rd, alu_data}),
      .pop        (grant_alu_s),
      .full       (alu_full_s),
      .empty      (alu_empty_s),
      .head       (alu_head_s),
      .count      (alu_count_s)
   );

   cdb_src_buf #(.DEPTH(BUF_DEPTH)) u_lsb_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_s),
      .push       (lsb_push_s),
      .push_entry ({lsb_rob_id, lsb_rd, lsb_data}),
      .pop        (grant_lsb_s),
      .full       (lsb_full_s),
      .empty      (lsb_empty_s),
      .head       (lsb_head_s),
      .count      (lsb_count_s)
   );

   // Round-robin grant from stored heads; rr only matters when both are pending
   always_comb begin
      grant_alu_s = 1'b0;
      grant_lsb_s = 1'b0;
      if (en && !flush_s) begin
         if (!alu_empty_s && !lsb_empty_s) begin
            grant_alu_s = (rr_r == CDB_SRC_ALU);
            grant_lsb_s = (rr_r == CDB_SRC_LSB);
         end else begin
            grant_alu_s = ~alu_empty_s;
            grant_lsb_s = ~lsb_empty_s;
         end
      end else begin
         grant_alu_s = 1'b0;
         grant_lsb_s = 1'b0;
      end
   end

   assign grant_src_s = grant_lsb_s ? CDB_SRC_LSB : CDB_SRC_ALU;

   // Broadcast register and rr pointer; payload holds when nothing is granted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_r        <= CDB_SRC_ALU;
         cdb_en_r    <= 1'b0;
         cdb_entry_r <= cdb_entry_t'({ENTRY_W{1'b0}});
         cdb_src_r   <= 1'b0;
      end else if (flush_s) begin
         rr_r     <= CDB_SRC_ALU;
         cdb_en_r <= 1'b0;
      end else if (grant_alu_s || grant_lsb_s) begin
         cdb_en_r    <= 1'b1;
         cdb_entry_r <= grant_alu_s ? alu_head_s : lsb_head_s;
         cdb_src_r   <= grant_src_s;
         rr_r        <= other_src(grant_src_s);
      end else begin
         cdb_en_r <= 1'b0;
      end
   end

   assign cdb_en     = cdb_en_r;
   assign cdb_rob_id = cdb_entry_r.rob_id;
   assign cdb_rd     = cdb_entry_r.rd;
   assign cdb_data   = cdb_entry_r.data;
   assign cdb_src    = cdb_src_r;

endmodule
